// File: rtl/user_io_pkg.sv
// Purpose: shared defaults and the pad-vector type for the user I/O conditioner and the core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   UIO_WIDTH        default number of conditioned pad bits (38)
//   UIO_SYNC_STAGES  default synchroniser depth
//   UIO_CNT_W        default per-bit debounce counter width
//   io_vec_t         one bit per pad, shared with the core's io_in port
package user_io_pkg;

    localparam int UIO_WIDTH       = 38;
    localparam int UIO_SYNC_STAGES = 2;
    localparam int UIO_CNT_W       = 4;

    typedef logic [UIO_WIDTH-1:0] io_vec_t;

endpackage

// File: rtl/user_io_debounce_bit.sv
// Purpose: per-pad synchroniser, debounce counter, clean level flop and rise/fall strobe flops.
// Latency: SYNC_STAGES+1 cycles in bypass; add db_ticks_i prescaler ticks when debouncing.
// Backpressure: none; the pad is sampled every cycle and strobes are never held off.
//
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   pad_i          raw asynchronous pad level
//   tick_i         shared debounce tick from the top-level prescaler
//   db_ticks_i     consecutive ticks needed to accept a change (0 = bypass)
//   clean_o        debounced level
//   rise_o/fall_o  one-cycle strobes on an accepted 0->1 / 1->0 change
module user_io_debounce_bit
    import user_io_pkg::*;
#(
    parameter int   SYNC_STAGES = UIO_SYNC_STAGES,  // must be >= 2
    parameter int   CNT_W       = UIO_CNT_W,
    parameter logic RESET_BIT   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pad_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] db_ticks_i,
    output logic             clean_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W:0]         cnt_inc;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Shift register: bit 0 takes the raw pad, the top bit is the usable level.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], pad_i};
    assign sync_bit = sync_q[SYNC_STAGES-1];

    // One bit wider than the counter so the acceptance compare cannot alias on wrap.
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_bit == clean_q) begin
            // Input agrees with the accepted level: any partial count was a glitch.
            cnt_d = '0;
        end else if ((db_ticks_i == '0) || (tick_i && (cnt_inc == {1'b0, db_ticks_i}))) begin
            clean_d = sync_bit;
            rise_d  = sync_bit;
            fall_d  = ~sync_bit;
            cnt_d   = '0;
        end else if (tick_i && (cnt_q != '1)) begin
            // Saturate rather than wrap; only reachable if db_ticks_i drops mid-count.
            cnt_d = cnt_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

    // An accepted change moves the level one way only, so both strobes can never coincide.
    a_strobe_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rise_q && fall_q));

endmodule

// File: rtl/user_io_conditioner.sv
// Purpose: synchronise, debounce and edge-detect the raw pad bus; sticky edge flags drive user_irq.
// Latency: clean/strobes SYNC_STAGES+1 cycles (+db_ticks_i ticks); pending +1 cycle; irq +1 more.
// Backpressure: none; every pad is sampled each cycle and flags are cleared by write-1 pulses.
//
// Ports:
//   wb_clk_i, wb_rst_ni  sole clock; asynchronous active-low reset
//   io_in                raw asynchronous pad inputs
//   prescale_i           debounce tick every prescale_i+1 cycles
//   db_ticks_i           consecutive ticks to accept a change; 0 = bypass
//   irq_mask_i, clr_i    per-bit interrupt enable; write-1-to-clear pending pulses
//   io_clean_o           debounced levels to the core
//   io_rise_o/io_fall_o  one-cycle strobes on accepted edges
//   pending_o, irq_o     sticky edge flags and registered |(pending_o & irq_mask_i)
//
// Build option USER_IO_COND_IRQ_EN: when defined, pending_o/irq_o are implemented;
// otherwise they are tied low and irq_mask_i/clr_i are ignored.
module user_io_conditioner
    import user_io_pkg::*;
#(
    parameter int               WIDTH       = UIO_WIDTH,
    parameter int               SYNC_STAGES = UIO_SYNC_STAGES,  // must be >= 2
    parameter int               CNT_W       = UIO_CNT_W,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [WIDTH-1:0] io_in,
    input  logic [15:0]      prescale_i,
    input  logic [CNT_W-1:0] db_ticks_i,
    input  logic [WIDTH-1:0] irq_mask_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] io_clean_o,
    output logic [WIDTH-1:0] io_rise_o,
    output logic [WIDTH-1:0] io_fall_o,
    output logic [WIDTH-1:0] pending_o,
    output logic             irq_o
);

    // ------------------------------------------------------------------
    // Prescaler: one tick whenever the count reaches prescale_i. The compare
    // is against the live input, so a new divider applies on the next match.
    // ------------------------------------------------------------------
    logic [15:0] pscnt_q, pscnt_d;
    logic        tick;

    assign tick    = (pscnt_q == prescale_i);
    assign pscnt_d = tick ? 16'd0 : (pscnt_q + 16'd1);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pscnt_q <= 16'd0;
        end else begin
            pscnt_q <= pscnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit conditioning
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] clean_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        user_io_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .RESET_BIT   (RESET_VAL[i])
        ) u_db (
            .clk_i      (wb_clk_i),
            .rst_ni     (wb_rst_ni),
            .pad_i      (io_in[i]),
            .tick_i     (tick),
            .db_ticks_i (db_ticks_i),
            .clean_o    (clean_w[i]),
            .rise_o     (rise_w[i]),
            .fall_o     (fall_w[i])
        );
    end

    assign io_clean_o = clean_w;
    assign io_rise_o  = rise_w;
    assign io_fall_o  = fall_w;

    // ------------------------------------------------------------------
    // Sticky flags and interrupt
    // ------------------------------------------------------------------
`ifdef USER_IO_COND_IRQ_EN
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             irq_q, irq_d;

    // A strobe in the same cycle as a clear pulse wins, so no edge is lost.
    assign pending_d = (pending_q & ~clr_i) | rise_w | fall_w;
    assign irq_d     = |(pending_q & irq_mask_i);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign pending_o = pending_q;
    assign irq_o     = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq_mask_i, clr_i};

    assign pending_o = '0;
    assign irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_user_io_conditioner.sv
// Purpose: randomized and directed bench for user_io_conditioner against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_user_io_conditioner;
    import user_io_pkg::*;

    localparam int WIDTH = UIO_WIDTH;
    localparam int SYNC  = UIO_SYNC_STAGES;
    localparam int CNT_W = UIO_CNT_W;
`ifdef USER_IO_COND_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    io_vec_t          io_in;
    logic [15:0]      prescale;
    logic [CNT_W-1:0] db_ticks;
    io_vec_t          irq_mask;
    io_vec_t          clr;
    io_vec_t          io_clean_o, io_rise_o, io_fall_o, pending_o;
    logic             irq_o;

    always #5 clk = ~clk;

    user_io_conditioner #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNT_W),
        .RESET_VAL   ('0)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .io_in      (io_in),
        .prescale_i (prescale),
        .db_ticks_i (db_ticks),
        .irq_mask_i (irq_mask),
        .clr_i      (clr),
        .io_clean_o (io_clean_o),
        .io_rise_o  (io_rise_o),
        .io_fall_o  (io_fall_o),
        .pending_o  (pending_o),
        .irq_o      (irq_o)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: pad delay line as a queue, per-bit tick counts as ints.
    // ------------------------------------------------------------------
    io_vec_t m_clean, m_rise, m_fall, m_pend;
    logic    m_irq;
    int      m_cnt [WIDTH];
    int      m_pcnt;
    io_vec_t m_hist [$];

    task automatic model_reset();
        m_clean = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
        m_pcnt = 0;
        for (int i = 0; i < WIDTH; i++) m_cnt[i] = 0;
        m_hist.delete();
        for (int j = 0; j < SYNC; j++) m_hist.push_back('0);
    endtask

    task automatic model_step();
        io_vec_t sv, n_clean, n_rise, n_fall;
        bit      tk;
        int      db;
        sv = m_hist[0];                       // pad value SYNC cycles old
        tk = (m_pcnt == int'(prescale));
        db = int'(db_ticks);
        n_clean = m_clean; n_rise = '0; n_fall = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sv[i] == m_clean[i]) begin
                m_cnt[i] = 0;
            end else if (db == 0 || (tk && m_cnt[i] + 1 == db)) begin
                n_clean[i] = sv[i];
                n_rise[i]  = sv[i];
                n_fall[i]  = !sv[i];
                m_cnt[i]   = 0;
            end else if (tk && m_cnt[i] < (1 << CNT_W) - 1) begin
                m_cnt[i]++;
            end
        end
        if (IRQ) begin
            m_irq  = |(m_pend & irq_mask);
            m_pend = (m_pend & ~clr) | m_rise | m_fall;
        end
        m_clean = n_clean; m_rise = n_rise; m_fall = n_fall;
        m_pcnt  = tk ? 0 : (m_pcnt + 1) % 65536;
        m_hist.push_back(io_in);
        void'(m_hist.pop_front());
    endtask

    // One clock: advance the model with the inputs present before the edge,
    // then compare all outputs 1 time unit after the edge.
    task automatic cycle();
        if (!rst_n) model_reset();
        else        model_step();
        @(posedge clk);
        #1;
        chk("clean",   io_clean_o, m_clean);
        chk("rise",    io_rise_o,  m_rise);
        chk("fall",    io_fall_o,  m_fall);
        chk("pending", pending_o,  m_pend);
        chk("irq",     irq_o,      m_irq);
    endtask

    task automatic wait_strobe(input int idx);
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            cycle();
            seen = io_rise_o[idx] | io_fall_o[idx];
        end
        chk($sformatf("strobe_bit%0d", idx), seen, 1);
    endtask

    initial begin
        int nrise, lat, lo, hi, nstb;
        bit v37;
        bit hist37 [$];

        // ---------------- reset with all pads high ----------------
        rst_n = 1'b0; io_in = '1; prescale = '0; db_ticks = '0;
        irq_mask = '0; clr = '0;
        model_reset();
        #1;
        chk("rst_clean", io_clean_o, '0);
        chk("rst_rise",  io_rise_o,  '0);
        chk("rst_fall",  io_fall_o,  '0);
        chk("rst_pend",  pending_o,  '0);
        chk("rst_irq",   irq_o,      0);
        repeat (3) cycle();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            chk($sformatf("post_rst_rise_c%0d", k), io_rise_o, (k == 3) ? {WIDTH{1'b1}} : '0);
        end

        // ---------------- debounced edge on bit 5 ----------------
        prescale = 16'd9; db_ticks = 4'd3; io_in = '0;
        repeat (60) cycle();
        io_in[5] = 1'b1;
        nrise = 0; lat = -1;
        for (int k = 1; k <= 60; k++) begin
            cycle();
            if (io_rise_o[5]) begin
                nrise++;
                if (lat < 0) lat = k;
                chk("db_clean_with_rise", io_clean_o[5], 1);
            end
        end
        // Counting starts the edge after the synchroniser delivers the level;
        // the first tick falls anywhere in one prescale period, then db-1 more periods.
        lo = SYNC + 1 + (3 - 1) * 10;
        hi = SYNC + 3 * 10;
        chk("db_rise_count", nrise, 1);
        chk("db_latency_window", (lat >= lo && lat <= hi), 1);
        chk("db_clean_final", io_clean_o[5], 1);

        // ---------------- glitch on bit 7 ----------------
        nstb = 0;
        io_in[7] = 1'b1;
        repeat (15) begin cycle(); nstb += int'(io_rise_o[7]) + int'(io_fall_o[7]); end
        io_in[7] = 1'b0;
        repeat (40) begin cycle(); nstb += int'(io_rise_o[7]) + int'(io_fall_o[7]); end
        chk("glitch_strobes", nstb, 0);
        chk("glitch_clean", io_clean_o[7], 0);

        // ---------------- pending and irq on bit 0 ----------------
        prescale = '0; db_ticks = '0; irq_mask = '0; irq_mask[0] = 1'b1;
        clr = '1; cycle(); clr = '0; cycle();
        io_in[0] = 1'b1; wait_strobe(0);
        repeat (3) cycle();
        clr[0] = 1'b1; cycle(); clr = '0; cycle();
        chk("pend_cleared", pending_o[0], 0);
        io_in[0] = 1'b0; wait_strobe(0);
        chk("fall_bit0", io_fall_o[0], 1);
        cycle();
        chk("pend_set", pending_o[0], IRQ);
        chk("irq_lags_pend", irq_o, 0);
        cycle();
        chk("irq_set", irq_o, IRQ);
        clr[0] = 1'b1; cycle(); clr = '0; cycle();
        chk("pend_clr2", pending_o[0], 0);
        io_in[0] = 1'b1; wait_strobe(0);
        clr[0] = 1'b1; cycle(); clr = '0;
        chk("set_beats_clr", pending_o[0], IRQ);
        repeat (3) cycle();

        // ---------------- bypass chatter on bit 37 ----------------
        v37 = io_in[37];
        for (int k = 0; k < 40; k++) begin
            v37 = !v37;
            io_in[37] = v37;
            hist37.push_back(v37);
            cycle();
            if (k >= 2) begin
                chk("chatter_clean", io_clean_o[37], hist37[k - 2]);
                chk("chatter_strobe", {io_rise_o[37], io_fall_o[37]},
                    hist37[k - 2] ? 2'b10 : 2'b01);
            end
        end

        // ---------------- randomized configurations with mid-run reset ----------------
        for (int c = 0; c < 4; c++) begin
            rst_n = 1'b0;
            #1;
            chk("midrst_clean", io_clean_o, '0);
            chk("midrst_strobes", io_rise_o | io_fall_o, '0);
            chk("midrst_pend", pending_o, '0);
            chk("midrst_irq", irq_o, 0);
            repeat (2) cycle();
            rst_n = 1'b1;
            prescale = 16'($urandom_range(0, 3));
            db_ticks = CNT_W'($urandom_range(0, 5));
            for (int i = 0; i < WIDTH; i++) irq_mask[i] = 1'($urandom_range(0, 1));
            for (int n = 0; n < 400; n++) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if ($urandom_range(0, 31) == 0) io_in[i] = !io_in[i];
                    clr[i] = ($urandom_range(0, 7) == 0);
                end
                cycle();
            end
            clr = '0;
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
